// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Data/instruction-address bus between the M-stage access unit (initiator)
//   and the memory / timer responder.
//   m_data_addr    initiator -> responder  byte address of the access
//   m_data_wdata   initiator -> responder  lane-replicated store data
//   m_data_byteen  initiator -> responder  per-byte write enables (0 = no write)
//   m_data_rdata   responder -> initiator  read word at m_data_addr, same cycle
//   m_inst_addr    initiator -> responder  PC of the M-stage instruction
interface mem_access_unit_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic [31:0] m_inst_addr;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    output m_inst_addr,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    input  m_inst_addr,
    output m_data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   M-stage data-bus initiator of the pipelined MIPS core. Builds address,
//   lane-replicated store data and byte enables, detects AdEL/AdES, and
//   registers the raw read word into the M->W stage where it is extracted and
//   sign/zero extended.
// Ports
//   clk, reset      clock (rising edge) and asynchronous active-high reset
//   m_op            0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB
//   m_addr          effective address; m_addr_ovf flags overflow in its add
//   m_wdata_raw     rt value used as store data
//   m_pc            PC of the M-stage instruction
//   req             CP0 flush this cycle; suppresses writes and load results
//   bus             master side of the data bus (addr/wdata/byteen/rdata/inst)
//   m_exc_code      0 none, 4 AdEL, 5 AdES (combinational)
//   w_load_we       W-stage load result valid
//   w_load_data     extended W-stage load result (0 when not valid)
//   w_pc            PC of the instruction now in W
module mem_access_unit #(
  parameter logic [31:0] DM_END   = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         m_op,
  input  logic [31:0]        m_addr,
  input  logic               m_addr_ovf,
  input  logic [31:0]        m_wdata_raw,
  input  logic [31:0]        m_pc,
  input  logic               req,
  mem_access_unit_if.master  bus,
  output logic [4:0]         m_exc_code,
  output logic               w_load_we,
  output logic [31:0]        w_load_data,
  output logic [31:0]        w_pc
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  logic [1:0]  off;
  logic        is_load;
  logic        is_store;
  logic        word_op;
  logic        half_op;
  logic        misaligned;
  logic        in_dm;
  logic        in_tc;
  logic        tc_count;
  logic        addr_bad;
  logic [3:0]  store_lanes;

  logic        w_valid;
  logic [31:0] w_rdata;
  logic [1:0]  w_off;
  logic [3:0]  w_op;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign off      = m_addr[1:0];
  assign is_load  = (m_op >= OP_LW) && (m_op <= OP_LBU);
  assign is_store = (m_op >= OP_SW) && (m_op <= OP_SB);
  assign word_op  = (m_op == OP_LW) || (m_op == OP_SW);
  assign half_op  = (m_op == OP_LH) || (m_op == OP_LHU) || (m_op == OP_SH);

  // Address classification. Timers only accept full-word accesses, and the
  // count register at +8 of each timer is read-only.
  assign misaligned = (word_op && (off != 2'b00)) || (half_op && off[0]);
  assign in_dm      = (m_addr <= DM_END);
  assign in_tc      = ((m_addr >= TC0_BASE) && (m_addr <= TC0_BASE + 32'd11)) ||
                      ((m_addr >= TC1_BASE) && (m_addr <= TC1_BASE + 32'd11));
  assign tc_count   = (m_addr == TC0_BASE + 32'd8) || (m_addr == TC1_BASE + 32'd8);
  assign addr_bad   = m_addr_ovf || misaligned || !(in_dm || in_tc) ||
                      (in_tc && !word_op) || (is_store && tc_count);

  // Every address fault shares one code; only the op type separates AdEL
  // from AdES.
  always_comb begin
    m_exc_code = EXC_NONE;
    if (addr_bad && is_load) begin
      m_exc_code = EXC_ADEL;
    end else if (addr_bad && is_store) begin
      m_exc_code = EXC_ADES;
    end
  end

  // Store lane selection and data replication so the responder can take the
  // lane it needs without shifting.
  always_comb begin
    store_lanes       = 4'b0000;
    bus.m_data_wdata  = m_wdata_raw;
    case (m_op)
      OP_SW: begin
        store_lanes = 4'b1111;
      end
      OP_SH: begin
        store_lanes      = off[1] ? 4'b1100 : 4'b0011;
        bus.m_data_wdata = {m_wdata_raw[15:0], m_wdata_raw[15:0]};
      end
      OP_SB: begin
        store_lanes      = 4'b0001 << off;
        bus.m_data_wdata = {4{m_wdata_raw[7:0]}};
      end
      default: begin
        store_lanes = 4'b0000;
      end
    endcase
  end

  // A flush or reset must never let a write reach the responder, and a
  // faulting store must not commit either.
  assign bus.m_data_byteen = (reset || req || (m_exc_code != EXC_NONE)) ? 4'b0000 : store_lanes;
  assign bus.m_data_addr   = m_addr;
  assign bus.m_inst_addr   = m_pc;

  // M->W stage register; the M stage never stalls so it loads every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_rdata <= 32'd0;
      w_off   <= 2'd0;
      w_op    <= 4'd0;
      w_pc    <= 32'd0;
    end else begin
      w_valid <= is_load && (m_exc_code == EXC_NONE) && !req;
      w_rdata <= bus.m_data_rdata;
      w_off   <= off;
      w_op    <= m_op;
      w_pc    <= m_pc;
    end
  end

  assign w_half = w_off[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_byte = w_rdata[7:0];
    case (w_off)
      2'd0: w_byte = w_rdata[7:0];
      2'd1: w_byte = w_rdata[15:8];
      2'd2: w_byte = w_rdata[23:16];
      2'd3: w_byte = w_rdata[31:24];
      default: w_byte = w_rdata[7:0];
    endcase
  end

  // Extraction is gated by the registered valid so a squashed or faulting
  // load reads back as zero.
  always_comb begin
    w_load_data = 32'd0;
    if (w_valid) begin
      case (w_op)
        OP_LW:   w_load_data = w_rdata;
        OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
        OP_LHU:  w_load_data = {16'd0, w_half};
        OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
        OP_LBU:  w_load_data = {24'd0, w_byte};
        default: w_load_data = 32'd0;
      endcase
    end
  end

  assign w_load_we = w_valid;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Drives mem_access_unit with directed and random M-stage operations. A
//   responder memory answers the bus; a separate behavioural model applies
//   the load/store rules directly and predicts every output, compared on
//   each falling clock edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  m_op;
  logic [31:0] m_addr;
  logic        m_addr_ovf;
  logic [31:0] m_wdata_raw;
  logic [31:0] m_pc;
  logic        req;
  logic [4:0]  m_exc_code;
  logic        w_load_we;
  logic [31:0] w_load_data;
  logic [31:0] w_pc;

  int errors = 0;
  int checks = 0;
  logic [31:0] pc_counter = 32'h0040_0000;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .m_op        (m_op),
    .m_addr      (m_addr),
    .m_addr_ovf  (m_addr_ovf),
    .m_wdata_raw (m_wdata_raw),
    .m_pc        (m_pc),
    .req         (req),
    .bus         (bus),
    .m_exc_code  (m_exc_code),
    .w_load_we   (w_load_we),
    .w_load_data (w_load_data),
    .w_pc        (w_pc)
  );

  always #5 clk = ~clk;

  // Responder memory: DM words plus eight timer slots covering 0x7F00..0x7F1F.
  logic [31:0] resp_dm [0:3071];
  logic [31:0] resp_tc [0:7];
  logic [31:0] model_dm [0:3071];
  logic [31:0] model_tc [0:7];
  logic [31:0] rdata_v;

  always_comb begin
    rdata_v = 32'hDEAD_BEEF;
    if (bus.m_data_addr <= 32'h0000_2FFF) begin
      rdata_v = resp_dm[bus.m_data_addr[13:2]];
    end else if (bus.m_data_addr >= 32'h0000_7F00 && bus.m_data_addr <= 32'h0000_7F1F) begin
      rdata_v = resp_tc[bus.m_data_addr[4:2]];
    end
  end
  assign bus.m_data_rdata = rdata_v;

  // The responder commits whatever lanes the DUT enables.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.m_data_byteen[i]) begin
        if (bus.m_data_addr <= 32'h0000_2FFF) begin
          resp_dm[bus.m_data_addr[13:2]][8*i +: 8] = bus.m_data_wdata[8*i +: 8];
        end else if (bus.m_data_addr >= 32'h0000_7F00 && bus.m_data_addr <= 32'h0000_7F1F) begin
          resp_tc[bus.m_data_addr[4:2]][8*i +: 8] = bus.m_data_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int access_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd6) return 4;
    if (op == 4'd2 || op == 4'd3 || op == 4'd7) return 2;
    return 1;
  endfunction

  function automatic bit op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic [4:0] model_exc(input logic [3:0] op, input logic [31:0] a, input logic ovf);
    bit in_dm, in_tc, bad;
    int sz;
    sz    = access_size(op);
    in_dm = (a <= 32'h2FFF);
    in_tc = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
    bad   = ovf || ((a % sz) != 0) || !(in_dm || in_tc) || (in_tc && sz != 4) ||
            (op_is_store(op) && (a == 32'h7F08 || a == 32'h7F18));
    if (!bad) return 5'd0;
    if (op_is_load(op)) return 5'd4;
    if (op_is_store(op)) return 5'd5;
    return 5'd0;
  endfunction

  function automatic logic [3:0] model_byteen(input logic [3:0] op, input logic [31:0] a,
                                              input logic ovf, input logic rq, input logic rst);
    if (rst || rq || !op_is_store(op) || model_exc(op, a, ovf) != 5'd0) return 4'b0000;
    if (op == 4'd6) return 4'b1111;
    if (op == 4'd7) return (a[1] ? 4'b1100 : 4'b0011);
    return 4'(1 << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] rt);
    if (op == 4'd7) return (rt & 32'hFFFF) * 32'h0001_0001;
    if (op == 4'd8) return (rt & 32'hFF) * 32'h0101_0101;
    return rt;
  endfunction

  function automatic logic [31:0] model_extract(input logic [3:0] op, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] hw, by;
    hw = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    by = (w >> (8 * int'(off))) & 32'hFF;
    case (op)
      4'd1: return w;
      4'd2: return hw[15] ? (hw | 32'hFFFF_0000) : hw;
      4'd3: return hw;
      4'd4: return by[7] ? (by | 32'hFFFF_FF00) : by;
      4'd5: return by;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a <= 32'h2FFF) return model_dm[a[13:2]];
    return model_tc[a[4:2]];
  endfunction

  task automatic model_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt);
    logic [31:0] old_w, new_w, mask;
    int sh;
    old_w = model_read(a);
    if (op == 4'd6) begin
      new_w = rt;
    end else begin
      sh    = (op == 4'd7) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
      mask  = ((op == 4'd7) ? 32'hFFFF : 32'hFF) << sh;
      new_w = (old_w & ~mask) | ((rt << sh) & mask);
    end
    if (a <= 32'h2FFF) model_dm[a[13:2]] = new_w;
    else model_tc[a[4:2]] = new_w;
  endtask

  logic        exp_we = 1'b0;
  logic [31:0] exp_data = 32'd0;
  logic [31:0] exp_pc = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_we   = 1'b0;
      exp_data = 32'd0;
      exp_pc   = 32'd0;
    end else begin
      exp_pc = m_pc;
      exp_we = op_is_load(m_op) && model_exc(m_op, m_addr, m_addr_ovf) == 5'd0 && !req;
      exp_data = exp_we ? model_extract(m_op, m_addr[1:0], model_read(m_addr)) : 32'd0;
      if (op_is_store(m_op) && model_exc(m_op, m_addr, m_addr_ovf) == 5'd0 && !req) begin
        model_store(m_op, m_addr, m_wdata_raw);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("exc", 32'(m_exc_code), 32'(model_exc(m_op, m_addr, m_addr_ovf)));
    checkOutput("byteen", 32'(bus.m_data_byteen), 32'(model_byteen(m_op, m_addr, m_addr_ovf, req, reset)));
    if (op_is_store(m_op)) begin
      checkOutput("wdata", bus.m_data_wdata, model_wdata(m_op, m_wdata_raw));
    end
    checkOutput("addr", bus.m_data_addr, m_addr);
    checkOutput("inst_addr", bus.m_inst_addr, m_pc);
    checkOutput("w_we", 32'(w_load_we), 32'(exp_we));
    checkOutput("w_data", w_load_data, exp_data);
    checkOutput("w_pc", w_pc, exp_pc);
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic ovf,
                               input logic [31:0] rt, input logic rq);
    @(negedge clk);
    #1;
    m_op        = op;
    m_addr      = a;
    m_addr_ovf  = ovf;
    m_wdata_raw = rt;
    req         = rq;
    m_pc        = pc_counter;
    pc_counter  = pc_counter + 32'd4;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    resp_dm[a[13:2]]  = v;
    model_dm[a[13:2]] = v;
  endtask

  function automatic logic [31:0] random_addr();
    int cat;
    logic [31:0] edges [0:7];
    edges[0] = 32'h2FFC; edges[1] = 32'h3000; edges[2] = 32'h7F0C; edges[3] = 32'h7F1C;
    edges[4] = 32'h7F08; edges[5] = 32'h7F18; edges[6] = 32'h7F00; edges[7] = 32'h0;
    cat = $urandom_range(0, 5);
    case (cat)
      0, 1: return 32'($urandom_range(0, 63));
      2:    return 32'($urandom_range(32'h2FC0, 32'h3007));
      3:    return 32'($urandom_range(32'h7EFC, 32'h7F23));
      4:    return $urandom;
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    reset = 1'b1; m_op = 4'd0; m_addr = 32'd0; m_addr_ovf = 1'b0;
    m_wdata_raw = 32'd0; m_pc = 32'd0; req = 1'b0;
    for (int i = 0; i < 3072; i++) begin
      v = $urandom;
      resp_dm[i] = v; model_dm[i] = v;
    end
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      resp_tc[i] = v; model_tc[i] = v;
    end
    #2;
    checkOutput("reset_we", 32'(w_load_we), 32'd0);
    checkOutput("reset_data", w_load_data, 32'd0);
    checkOutput("reset_pc", w_pc, 32'd0);
    checkOutput("reset_byteen", 32'(bus.m_data_byteen), 32'd0);
    @(negedge clk); #1; reset = 1'b0;

    // Byte store to the top lane replicates the byte.
    applyStimulus(4'd8, 32'h1003, 1'b0, 32'h1234_5678, 1'b0);
    #2;
    checkOutput("sb_byteen", 32'(bus.m_data_byteen), 32'h8);
    checkOutput("sb_wdata", bus.m_data_wdata, 32'h7878_7878);
    checkOutput("sb_exc", 32'(m_exc_code), 32'd0);
    @(posedge clk); #1;
    set_word(32'h1000, 32'h8001_7FFF);

    // Upper halfword, sign then zero extension.
    applyStimulus(4'd2, 32'h1002, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("lh_we", 32'(w_load_we), 32'd1);
    checkOutput("lh_data", w_load_data, 32'hFFFF_8001);
    applyStimulus(4'd3, 32'h1002, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("lhu_data", w_load_data, 32'h0000_8001);

    applyStimulus(4'd1, 32'h1001, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("lw_mis_exc", 32'(m_exc_code), 32'd4);
    checkOutput("lw_mis_byteen", 32'(bus.m_data_byteen), 32'd0);
    @(posedge clk); #1;
    checkOutput("lw_mis_we", 32'(w_load_we), 32'd0);

    applyStimulus(4'd6, 32'h7F08, 1'b0, 32'hAAAA_5555, 1'b0);
    #2;
    checkOutput("sw_count_exc", 32'(m_exc_code), 32'd5);
    checkOutput("sw_count_byteen", 32'(bus.m_data_byteen), 32'd0);
    applyStimulus(4'd6, 32'h7F04, 1'b0, 32'h0000_1234, 1'b0);
    #2;
    checkOutput("sw_tc_byteen", 32'(bus.m_data_byteen), 32'hF);
    checkOutput("sw_tc_exc", 32'(m_exc_code), 32'd0);

    applyStimulus(4'd6, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    #2;
    checkOutput("sw_req_byteen", 32'(bus.m_data_byteen), 32'd0);
    applyStimulus(4'd1, 32'h1000, 1'b0, 32'd0, 1'b1);
    @(posedge clk); #1;
    checkOutput("lw_req_we", 32'(w_load_we), 32'd0);

    applyStimulus(4'd4, 32'h3000, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("lb_range_exc", 32'(m_exc_code), 32'd4);
    applyStimulus(4'd4, 32'h0100, 1'b1, 32'd0, 1'b0);
    #2;
    checkOutput("lb_ovf_exc", 32'(m_exc_code), 32'd4);
    applyStimulus(4'd2, 32'h7F00, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("lh_tc_exc", 32'(m_exc_code), 32'd4);
    applyStimulus(4'd1, 32'h2FFC, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("lw_end_exc", 32'(m_exc_code), 32'd0);
    applyStimulus(4'd6, 32'h3000, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("sw_3000_exc", 32'(m_exc_code), 32'd5);
    applyStimulus(4'd1, 32'h7F0C, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("lw_7f0c_exc", 32'(m_exc_code), 32'd4);
    applyStimulus(4'd1, 32'h7F1C, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("lw_7f1c_exc", 32'(m_exc_code), 32'd4);

    // Mid-cycle reset clears the W stage before the next edge.
    applyStimulus(4'd1, 32'h1000, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("lw_pre_we", 32'(w_load_we), 32'd1);
    checkOutput("lw_pre_data", w_load_data, 32'h8001_7FFF);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_we", 32'(w_load_we), 32'd0);
    checkOutput("async_data", w_load_data, 32'd0);
    checkOutput("async_pc", w_pc, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    applyStimulus(4'd1, 32'h1000, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("post_rst_we", 32'(w_load_we), 32'd1);
    checkOutput("post_rst_data", w_load_data, 32'h8001_7FFF);

    // Randomised traffic checked by the model on every falling edge.
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [3:0] op;
      r  = $urandom_range(0, 11);
      op = (r <= 8) ? 4'(r) : 4'($urandom_range(9, 15));
      applyStimulus(op, random_addr(), ($urandom_range(0, 15) == 0), $urandom,
                    ($urandom_range(0, 7) == 0));
    end

    applyStimulus(4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
